// File: rtl/cia_serial_adder.sv
// cia_serial_adder: multi-cycle carry-increment adder, one BLK-bit block per clock.
// Ports: clk, rst (sync, active-high), start/a/b/cin/sub in; busy/done/sum/cout/ovf out.
// Optional subtract path enabled by defining CIA_SUB_EN.
module cia_serial_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / BLK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res;
  logic             carry;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

`ifdef CIA_SUB_EN
  // Two's-complement subtract: invert b and inject a carry of one.
  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub ? 1'b1 : cin;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = cin;
`endif

  logic [BLK-1:0]   a_blk;
  logic [BLK-1:0]   b_blk;
  logic [BLK:0]     s0;
  logic [BLK:0]     s1;
  logic [BLK:0]     blk;
  logic [WIDTH-1:0] res_nxt;
  logic             last;
  logic             msb_cin;
  int               base;

  always_comb begin
    base    = int'(cnt) * BLK;
    a_blk   = a_r[base +: BLK];
    b_blk   = b_r[base +: BLK];
    s0      = {1'b0, a_blk} + {1'b0, b_blk};
    s1      = s0 + (BLK+1)'(1);
    blk     = carry ? s1 : s0;
    res_nxt = res;
    res_nxt[base +: BLK] = blk[BLK-1:0];
    // Carry into the top bit of this block, recovered from its sum bit.
    msb_cin = a_blk[BLK-1] ^ b_blk[BLK-1] ^ blk[BLK-1];
    last    = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b_eff;
            carry <= c_eff;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= blk[BLK];
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_nxt;
            cout  <= blk[BLK];
            ovf   <= msb_cin ^ blk[BLK];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cia_serial_adder.sv
// tb_cia_serial_adder: directed bench with result scoreboard for cia_serial_adder.
// Covers reset, latency, carry chain, overflow, back-to-back, mid-run reset, block sizes.
module tb_cia_serial_adder;

`ifdef CIA_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_x = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        busy, done, cout, ovf;
  logic [31:0] sum;
  logic        busy1, done1, cout1, ovf1;
  logic [31:0] sum1;
  logic        busy2, done2, cout2, ovf2;
  logic [31:0] sum2;

  int checks = 0;
  int errors = 0;
  logic [33:0] sbq[$];
  logic [33:0] mon_e;

  always #5 clk = ~clk;

  cia_serial_adder #(.WIDTH(32), .BLK(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy), .done(done),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  cia_serial_adder #(.WIDTH(32), .BLK(1)) u1 (
    .clk(clk), .rst(rst), .start(start_x), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  cia_serial_adder #(.WIDTH(32), .BLK(32)) u2 (
    .clk(clk), .rst(rst), .start(start_x), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy2), .done(done2),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [33:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        ci,
    input logic        s
  );
    logic [31:0] yy;
    logic        c;
    logic [32:0] full;
    logic [31:0] low;
    yy = y;
    c  = ci;
    if (SUB_EN && s) begin
      yy = ~y;
      c  = 1'b1;
    end
    full = {1'b0, x} + {1'b0, yy} + 33'(c);
    low  = {1'b0, x[30:0]} + {1'b0, yy[30:0]} + 32'(c);
    return {full[32] ^ low[31], full[32], full[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s);
    int n;
    a = x;
    b = y;
    cin = ci;
    sub = s;
    start = 1'b1;
    sbq.push_back(model(x, y, ci, s));
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cin = 1'b0;
    sub = 1'b0;
    wait_done(1, n);
    chk("latency", 64'(n), 64'd9);
    tick();
  endtask

  task automatic lat_op(input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s);
    logic [33:0] ex;
    logic [33:0] r1, r2;
    int n1, n2;
    n1 = 0;
    n2 = 0;
    r1 = '0;
    r2 = '0;
    a = x;
    b = y;
    cin = ci;
    sub = s;
    ex = model(x, y, ci, s);
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    a = $urandom;
    b = $urandom;
    for (int n = 1; n <= 40; n++) begin
      if (done1 && n1 == 0) begin
        n1 = n;
        r1 = {ovf1, cout1, sum1};
      end
      if (done2 && n2 == 0) begin
        n2 = n;
        r2 = {ovf2, cout2, sum2};
      end
      tick();
    end
    chk("blk1_latency", 64'(n1), 64'd33);
    chk("blk32_latency", 64'(n2), 64'd2);
    chk("blk1_result", 64'(r1), 64'(ex));
    chk("blk32_result", 64'(r2), 64'(ex));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (done) begin
        chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          chk("result", 64'({ovf, cout, sum}), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", 64'({busy, done, cout, ovf, sum}), 64'd0);
    rst = 1'b0;
    repeat (20) begin
      tick();
      chk("idle_quiet", 64'({busy, done}), 64'd0);
    end
    chk("idle_outputs", 64'({cout, ovf, sum}), 64'd0);

    // Full carry ripple through every block.
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    cin = 1'b0;
    start = 1'b1;
    sbq.push_back(model(a, b, cin, 1'b0));
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("op1_busy", 64'({busy, done}), 64'b10);
      tick();
    end
    chk("op1_done", 64'({busy, done}), 64'b01);
    chk("op1_sum", 64'({ovf, cout, sum}), 64'({1'b0, 1'b1, 32'h0}));
    tick();
    chk("op1_done_width", 64'(done), 64'd0);

    // Signed overflow plus an ignored start mid-run.
    a = 32'h7FFF_FFFF;
    b = 32'h0000_0001;
    cin = 1'b1;
    start = 1'b1;
    sbq.push_back(model(a, b, cin, 1'b0));
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 32'hDEAD_BEEF;
    b = 32'h0101_0101;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(4, n);
    chk("op2_latency", 64'(n), 64'd9);
    chk("op2_sum", 64'({ovf, cout, sum}),
        64'({1'b1, 1'b0, 32'h8000_0001}));
    tick();

    // Back-to-back with start held high.
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    cin = 1'b0;
    start = 1'b1;
    sbq.push_back(model(a, b, cin, 1'b0));
    tick();
    a = 32'd5;
    b = 32'd3;
    wait_done(1, n);
    chk("b2b_first_latency", 64'(n), 64'd9);
    chk("b2b_first_sum", 64'(sum), 64'h2345_6789);
    sbq.push_back(model(a, b, cin, 1'b0));
    tick();
    start = 1'b0;
    chk("b2b_done_width", 64'({busy, done}), 64'b10);
    wait_done(1, n);
    chk("b2b_spacing", 64'(n), 64'd9);
    chk("b2b_second_sum", 64'(sum), 64'd8);
    tick();

    // Reset in the middle of a run discards it.
    a = 32'hAAAA_AAAA;
    b = 32'h5555_5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrun_rst", 64'({busy, done, cout, ovf, sum}), 64'd0);
    rst = 1'b0;
    repeat (12) begin
      tick();
      chk("no_done_after_rst", 64'({busy, done}), 64'd0);
    end

    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(32'h0F0F_F0F0, 32'hF0F1_0F0F, 1'b0, 1'b0);
    if (SUB_EN) begin
      run_op(32'd5, 32'd7, 1'b0, 1'b1);
      run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      run_op(32'd5, 32'd7, 1'b1, 1'b0);
    end

    lat_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    lat_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    if (SUB_EN) begin
      lat_op(32'd5, 32'd7, 1'b0, 1'b1);
      lat_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    end

    repeat (3) tick();
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
